// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end feeding the decode/register stage.
// Owns the fetch PC, reads instruction memory over a req/ack handshake that
// tolerates wait states, and buffers {pc, instr} pairs in a DEPTH-entry FIFO.
// A redirect flushes the FIFO and restarts fetch at the target; a request
// already on the bus when the redirect arrives is completed and dropped (DRAIN).
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   imem_req/imem_addr      read request and word-aligned address
//   imem_ack/imem_rdata     request completion and returned instruction
//   redirect/redirect_pc    flush + new fetch PC (bits [1:0] ignored)
//   out_valid/out_ready     head-of-queue handshake to the datapath
//   out_instr/out_pc/out_pc4 head entry (zero when empty)
//   count                   FIFO occupancy
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_pc4,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, DRAIN} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     drain_addr_q, drain_addr_d;
  logic [AW-1:0]   rptr_q, wptr_q;
  logic [CW-1:0]   count_q;
  fq_entry_t       mem_q [DEPTH];

  logic            push, pop;
  logic [31:0]     tgt_pc;
  fq_entry_t       head;

  assign tgt_pc = {redirect_pc[31:2], 2'b00};

  // Next state, request generation and push decision.
  // imem_req is gated by rst_n so it drops the instant reset asserts.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    push         = 1'b0;
    imem_req     = 1'b0;
    imem_addr    = fetch_pc_q;
    case (state_q)
      RUN: begin
        imem_req  = rst_n && (count_q < CW'(DEPTH));
        imem_addr = fetch_pc_q;
        if (redirect) begin
          fetch_pc_d = tgt_pc;
          // A started-but-unacked request cannot be withdrawn: finish it blind.
          if (imem_req && !imem_ack) begin
            drain_addr_d = fetch_pc_q;
            state_d      = DRAIN;
          end
        end else if (imem_req && imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      DRAIN: begin
        imem_req  = rst_n;
        imem_addr = drain_addr_q;
        if (redirect) fetch_pc_d = tgt_pc;
        if (imem_ack) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready && !redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= '0;
      rptr_q       <= '0;
      wptr_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      if (redirect) begin
        rptr_q  <= '0;
        wptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + AW'(1);
        if (pop)  rptr_q <= rptr_q + AW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Entry storage needs no reset: it is only read when count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{pc: fetch_pc_q, instr: imem_rdata};
  end

  assign head      = mem_q[rptr_q];
  assign out_instr = out_valid ? head.instr : 32'd0;
  assign out_pc    = out_valid ? head.pc    : 32'd0;
  assign out_pc4   = out_valid ? head.pc + 32'd4 : 32'd0;
  assign count     = count_q;

endmodule
